// File: rtl/mem_access_stage_if.sv
// Shared definitions and the data-memory bus interface for the MEM stage.
//
// mem_access_pkg
//   load_align_t : tells writeback which byte/half lanes of the raw word to extract.
//
// mem_access_stage_if : data-memory request/response bus
//   addr   word-aligned byte address            (stage -> memory)
//   rmask  byte read mask, nonzero while a load is outstanding
//   wmask  byte write mask, nonzero while a store is outstanding
//   wdata  lane-shifted store data              (stage -> memory)
//   rdata  read data, valid together with resp  (memory -> stage)
//   resp   one-cycle completion pulse           (memory -> stage)
//   Modports: master = MEM stage, slave = memory.

package mem_access_pkg;
  typedef enum logic [2:0] {
    la_nothing = 3'd0,
    la_lw      = 3'd1,
    la_lhw_l   = 3'd2,
    la_lhw_u   = 3'd3,
    la_lb_l    = 3'd4,
    la_lb_ml   = 3'd5,
    la_lb_mu   = 3'd6,
    la_lb_u    = 3'd7
  } load_align_t;
endpackage

interface mem_access_stage_if;
  logic [31:0] addr;
  logic [3:0]  rmask;
  logic [3:0]  wmask;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        resp;

  modport master (output addr, rmask, wmask, wdata, input rdata, resp);
  modport slave  (input addr, rmask, wmask, wdata, output rdata, resp);
endinterface

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage between the EX/MEM register and the combinational
// writeback stage. Accepts one op per ex_valid/ex_ready handshake, issues the
// data-memory request, stalls upstream until the memory responds (or a timeout
// aborts the access) and produces the MEM/WB register.
//
// Ports
//   clk, rst_n        clock / async active-low reset
//   ex_valid          EX/MEM holds a valid op
//   ex_is_load/store  op class (mutually exclusive)
//   ex_funct3         RV32I width/sign code
//   ex_addr           effective byte address
//   ex_wdata          unshifted store data
//   ex_payload        opaque passthrough fields
//   ex_ready          stage can accept an op this cycle (IDLE only)
//   dmem              data-memory bus (master side)
//   wb_valid          one-cycle pulse per completed op
//   wb_load_align     lane-extraction code for writeback
//   wb_mem_rdata      raw captured read word (0 for non-loads)
//   wb_payload        registered passthrough fields
//   wb_misaligned     op was misaligned, no memory access made
//   wb_bus_err        op aborted by timeout

module mem_access_stage
  import mem_access_pkg::*;
#(
  parameter int PAYLOAD_W   = 96,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ex_valid,
  input  logic                 ex_is_load,
  input  logic                 ex_is_store,
  input  logic [2:0]           ex_funct3,
  input  logic [31:0]          ex_addr,
  input  logic [31:0]          ex_wdata,
  input  logic [PAYLOAD_W-1:0] ex_payload,
  output logic                 ex_ready,
  mem_access_stage_if.master   dmem,
  output logic                 wb_valid,
  output load_align_t          wb_load_align,
  output logic [31:0]          wb_mem_rdata,
  output logic [PAYLOAD_W-1:0] wb_payload,
  output logic                 wb_misaligned,
  output logic                 wb_bus_err
);

  typedef enum logic {st_idle, st_wait} state_t;

  // Last counter value of a WAIT period that is allowed to pass without a
  // response; the counter holds (WAIT cycle index - 1).
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

  state_t               state_q, state_d;
  logic [31:0]          req_addr_q;
  logic [3:0]           req_mask_q;
  logic                 req_is_load_q;
  logic [31:0]          req_wdata_q;
  load_align_t          pend_align_q;
  logic [PAYLOAD_W-1:0] pend_payload_q;
  logic [7:0]           timeout_cnt_q;

  // Decode of the op presented by EX/MEM.
  logic        is_mem;
  logic        misaligned;
  logic [3:0]  byte_mask;
  load_align_t load_align;
  logic        timeout_hit;

  // FSM control strobes.
  logic accept_mem;
  logic pass_through;
  logic complete;
  logic abort;

  assign is_mem = ex_is_load | ex_is_store;

  // NOTE: every signal written here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    misaligned = 1'b0;
    byte_mask  = 4'b1111;
    load_align = la_nothing;
    // funct3[1:0] encodes access size for both loads and stores: 0=b, 1=h, 2=w.
    case (ex_funct3[1:0])
      2'b00: byte_mask = 4'b0001 << ex_addr[1:0];
      2'b01: begin
        byte_mask  = 4'b0011 << ex_addr[1:0];
        misaligned = is_mem & ex_addr[0];
      end
      default: misaligned = is_mem & (ex_addr[1:0] != 2'b00);
    endcase
    if (ex_is_load) begin
      case (ex_funct3[1:0])
        2'b00: begin
          case (ex_addr[1:0])
            2'd0:    load_align = la_lb_l;
            2'd1:    load_align = la_lb_ml;
            2'd2:    load_align = la_lb_mu;
            default: load_align = la_lb_u;
          endcase
        end
        2'b01:   load_align = ex_addr[1] ? la_lhw_u : la_lhw_l;
        default: load_align = la_lw;
      endcase
    end
  end

  assign timeout_hit = (TIMEOUT_CYC != 0) && (timeout_cnt_q == TIMEOUT_LAST);

  // ex_ready depends on state only, keeping EX free of a combinational loop.
  assign ex_ready = (state_q == st_idle);

  always_comb begin
    state_d      = state_q;
    accept_mem   = 1'b0;
    pass_through = 1'b0;
    complete     = 1'b0;
    abort        = 1'b0;
    case (state_q)
      st_idle: begin
        if (ex_valid) begin
          if (is_mem && !misaligned) begin
            accept_mem = 1'b1;
            state_d    = st_wait;
          end else begin
            pass_through = 1'b1;
          end
        end
      end
      st_wait: begin
        // A response in the timeout cycle still completes normally.
        if (dmem.resp) begin
          complete = 1'b1;
          state_d  = st_idle;
        end else if (timeout_hit) begin
          abort   = 1'b1;
          state_d = st_idle;
        end
      end
      default: state_d = st_idle;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= st_idle;
    else        state_q <= state_d;
  end

  // Request registers: captured on acceptance and held stable through WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_addr_q     <= '0;
      req_mask_q     <= '0;
      req_is_load_q  <= 1'b0;
      req_wdata_q    <= '0;
      pend_align_q   <= la_nothing;
      pend_payload_q <= '0;
      timeout_cnt_q  <= '0;
    end else begin
      if (accept_mem) begin
        req_addr_q     <= {ex_addr[31:2], 2'b00};
        req_mask_q     <= byte_mask;
        req_is_load_q  <= ex_is_load;
        req_wdata_q    <= ex_wdata << {ex_addr[1:0], 3'b000};
        pend_align_q   <= load_align;
        pend_payload_q <= ex_payload;
        timeout_cnt_q  <= '0;
      end else if (state_q == st_wait) begin
        timeout_cnt_q <= timeout_cnt_q + 8'd1;
      end
    end
  end

  // Masks are gated by state so they drop on the edge that leaves WAIT,
  // including an asynchronous reset.
  assign dmem.addr  = req_addr_q;
  assign dmem.wdata = req_wdata_q;
  assign dmem.rmask = (state_q == st_wait &&  req_is_load_q) ? req_mask_q : 4'b0000;
  assign dmem.wmask = (state_q == st_wait && !req_is_load_q) ? req_mask_q : 4'b0000;

  // MEM/WB register: wb_valid pulses for one cycle, the rest holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid      <= 1'b0;
      wb_load_align <= la_nothing;
      wb_mem_rdata  <= '0;
      wb_payload    <= '0;
      wb_misaligned <= 1'b0;
      wb_bus_err    <= 1'b0;
    end else begin
      wb_valid <= pass_through | complete | abort;
      if (pass_through) begin
        wb_load_align <= la_nothing;
        wb_mem_rdata  <= '0;
        wb_payload    <= ex_payload;
        wb_misaligned <= misaligned;
        wb_bus_err    <= 1'b0;
      end else if (complete) begin
        wb_load_align <= pend_align_q;
        wb_mem_rdata  <= req_is_load_q ? dmem.rdata : 32'd0;
        wb_payload    <= pend_payload_q;
        wb_misaligned <= 1'b0;
        wb_bus_err    <= 1'b0;
      end else if (abort) begin
        // No data came back, so writeback gets nothing to extract.
        wb_load_align <= la_nothing;
        wb_mem_rdata  <= '0;
        wb_payload    <= pend_payload_q;
        wb_misaligned <= 1'b0;
        wb_bus_err    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with TIMEOUT_CYC=4. Inputs are driven
// and outputs sampled 1 time unit after each rising edge.

module tb_mem_access_stage;
  import mem_access_pkg::*;

  localparam int PW = 96;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ex_valid, ex_is_load, ex_is_store;
  logic [2:0]    ex_funct3;
  logic [31:0]   ex_addr, ex_wdata;
  logic [PW-1:0] ex_payload;
  logic          ex_ready;
  logic          wb_valid, wb_misaligned, wb_bus_err;
  load_align_t   wb_load_align;
  logic [31:0]   wb_mem_rdata;
  logic [PW-1:0] wb_payload;

  int total = 0;
  int bad   = 0;

  mem_access_stage_if dmem ();

  mem_access_stage #(.PAYLOAD_W(PW), .TIMEOUT_CYC(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid      (ex_valid),
    .ex_is_load    (ex_is_load),
    .ex_is_store   (ex_is_store),
    .ex_funct3     (ex_funct3),
    .ex_addr       (ex_addr),
    .ex_wdata      (ex_wdata),
    .ex_payload    (ex_payload),
    .ex_ready      (ex_ready),
    .dmem          (dmem.master),
    .wb_valid      (wb_valid),
    .wb_load_align (wb_load_align),
    .wb_mem_rdata  (wb_mem_rdata),
    .wb_payload    (wb_payload),
    .wb_misaligned (wb_misaligned),
    .wb_bus_err    (wb_bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [PW-1:0] pl);
    ex_valid    = 1'b1;
    ex_is_load  = ld;
    ex_is_store = st;
    ex_funct3   = f3;
    ex_addr     = a;
    ex_wdata    = wd;
    ex_payload  = pl;
  endtask

  task automatic idle_ex();
    ex_valid    = 1'b0;
    ex_is_load  = 1'b0;
    ex_is_store = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_ex();
    ex_funct3  = 3'd0;
    ex_addr    = '0;
    ex_wdata   = '0;
    ex_payload = '0;
    dmem.rdata = '0;
    dmem.resp  = 1'b0;

    // Reset state.
    step();
    check("rst_ex_ready", 128'(ex_ready), 128'(1'b1));
    check("rst_wb_valid", 128'(wb_valid), 128'(1'b0));
    check("rst_rmask", 128'(dmem.rmask), 128'(4'b0000));
    check("rst_wmask", 128'(dmem.wmask), 128'(4'b0000));
    check("rst_addr", 128'(dmem.addr), 128'(32'h0));
    check("rst_payload", 128'(wb_payload), 128'(96'h0));
    rst_n = 1'b1;
    step();

    // Non-memory op passes straight through in one cycle.
    drive_op(1'b0, 1'b0, 3'd0, 32'h0000_1234, 32'h0, 96'h1111_2222_3333_4444_5555_6666);
    check("add_masks_before", 128'({dmem.rmask, dmem.wmask}), 128'(8'h00));
    step();
    idle_ex();
    check("add_wb_valid", 128'(wb_valid), 128'(1'b1));
    check("add_align", 128'(wb_load_align), 128'(la_nothing));
    check("add_payload", 128'(wb_payload), 128'(96'h1111_2222_3333_4444_5555_6666));
    check("add_rdata", 128'(wb_mem_rdata), 128'(32'h0));
    check("add_masks", 128'({dmem.rmask, dmem.wmask}), 128'(8'h00));
    step();
    check("add_pulse_drop", 128'(wb_valid), 128'(1'b0));
    check("add_payload_hold", 128'(wb_payload), 128'(96'h1111_2222_3333_4444_5555_6666));

    // lb 0x1003, response three cycles after acceptance.
    drive_op(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 96'hA);
    step();
    idle_ex();
    check("lb_rmask_c1", 128'(dmem.rmask), 128'(4'b1000));
    check("lb_ready_c1", 128'(ex_ready), 128'(1'b0));
    check("lb_addr", 128'(dmem.addr), 128'(32'h0000_1000));
    check("lb_wmask", 128'(dmem.wmask), 128'(4'b0000));
    step();
    check("lb_rmask_c2", 128'(dmem.rmask), 128'(4'b1000));
    check("lb_wb_valid_c2", 128'(wb_valid), 128'(1'b0));
    step();
    dmem.resp  = 1'b1;
    dmem.rdata = 32'h80AA_BBCC;
    check("lb_rmask_c3", 128'(dmem.rmask), 128'(4'b1000));
    check("lb_ready_c3", 128'(ex_ready), 128'(1'b0));
    step();
    dmem.resp  = 1'b0;
    dmem.rdata = 32'hDEAD_DEAD;
    check("lb_wb_valid", 128'(wb_valid), 128'(1'b1));
    check("lb_rdata", 128'(wb_mem_rdata), 128'(32'h80AA_BBCC));
    check("lb_align", 128'(wb_load_align), 128'(la_lb_u));
    check("lb_payload", 128'(wb_payload), 128'(96'hA));
    check("lb_rmask_drop", 128'(dmem.rmask), 128'(4'b0000));
    check("lb_ready_back", 128'(ex_ready), 128'(1'b1));

    // sh 0x2002, response one cycle after acceptance.
    drive_op(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 96'hB);
    step();
    idle_ex();
    check("sh_wmask", 128'(dmem.wmask), 128'(4'b1100));
    check("sh_wdata", 128'(dmem.wdata), 128'(32'hBEEF_0000));
    check("sh_addr", 128'(dmem.addr), 128'(32'h0000_2000));
    check("sh_rmask", 128'(dmem.rmask), 128'(4'b0000));
    dmem.resp = 1'b1;
    step();
    dmem.resp = 1'b0;
    check("sh_wb_valid", 128'(wb_valid), 128'(1'b1));
    check("sh_wmask_drop", 128'(dmem.wmask), 128'(4'b0000));
    check("sh_rdata", 128'(wb_mem_rdata), 128'(32'h0));
    check("sh_align", 128'(wb_load_align), 128'(la_nothing));

    // Misaligned lw 0x3001: no request, flagged next cycle.
    drive_op(1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'h0, 96'hC);
    step();
    idle_ex();
    check("mis_wb_valid", 128'(wb_valid), 128'(1'b1));
    check("mis_flag", 128'(wb_misaligned), 128'(1'b1));
    check("mis_masks", 128'({dmem.rmask, dmem.wmask}), 128'(8'h00));
    check("mis_ready", 128'(ex_ready), 128'(1'b1));
    check("mis_align", 128'(wb_load_align), 128'(la_nothing));
    step();
    check("mis_pulse_drop", 128'(wb_valid), 128'(1'b0));
    check("mis_flag_hold", 128'(wb_misaligned), 128'(1'b1));

    // dmem_resp in IDLE is ignored.
    dmem.resp = 1'b1;
    step();
    dmem.resp = 1'b0;
    check("idle_resp_wb_valid", 128'(wb_valid), 128'(1'b0));
    check("idle_resp_ready", 128'(ex_ready), 128'(1'b1));

    // lw with no response: abort after four WAIT cycles.
    drive_op(1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'h0, 96'hD);
    step();
    idle_ex();
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("to_rmask_c%0d", i), 128'(dmem.rmask), 128'(4'b1111));
      check($sformatf("to_wb_valid_c%0d", i), 128'(wb_valid), 128'(1'b0));
      if (i < 4) step();
    end
    step();
    check("to_wb_valid", 128'(wb_valid), 128'(1'b1));
    check("to_bus_err", 128'(wb_bus_err), 128'(1'b1));
    check("to_rdata", 128'(wb_mem_rdata), 128'(32'h0));
    check("to_ready", 128'(ex_ready), 128'(1'b1));
    check("to_rmask_drop", 128'(dmem.rmask), 128'(4'b0000));
    check("to_payload", 128'(wb_payload), 128'(96'hD));

    // lw with response in the fourth WAIT cycle: normal completion wins.
    drive_op(1'b1, 1'b0, 3'b010, 32'h0000_4004, 32'h0, 96'hE);
    step();
    idle_ex();
    step();
    step();
    step();
    dmem.resp  = 1'b1;
    dmem.rdata = 32'h1234_5678;
    step();
    dmem.resp = 1'b0;
    check("race_wb_valid", 128'(wb_valid), 128'(1'b1));
    check("race_bus_err", 128'(wb_bus_err), 128'(1'b0));
    check("race_rdata", 128'(wb_mem_rdata), 128'(32'h1234_5678));
    check("race_align", 128'(wb_load_align), 128'(la_lw));

    // Reset asserted mid-WAIT drops the op immediately.
    drive_op(1'b1, 1'b0, 3'b000, 32'h0000_5001, 32'h0, 96'hF);
    step();
    idle_ex();
    check("rstw_rmask_before", 128'(dmem.rmask), 128'(4'b0010));
    #2 rst_n = 1'b0;
    #1;
    check("rstw_rmask", 128'(dmem.rmask), 128'(4'b0000));
    check("rstw_ready", 128'(ex_ready), 128'(1'b1));
    check("rstw_wb_valid", 128'(wb_valid), 128'(1'b0));
    #1 rst_n = 1'b1;
    step();
    check("rstw_no_wb", 128'(wb_valid), 128'(1'b0));

    // lhu 0x7002, k=1: upper halfword.
    drive_op(1'b1, 1'b0, 3'b101, 32'h0000_7002, 32'h0, 96'h7);
    step();
    idle_ex();
    check("lhu_rmask", 128'(dmem.rmask), 128'(4'b1100));
    dmem.resp  = 1'b1;
    dmem.rdata = 32'hCAFE_0000;
    step();
    dmem.resp = 1'b0;
    check("lhu_align", 128'(wb_load_align), 128'(la_lhw_u));
    check("lhu_rdata", 128'(wb_mem_rdata), 128'(32'hCAFE_0000));

    // Back-to-back lw/lw with k=1: wb_valid every two cycles.
    drive_op(1'b1, 1'b0, 3'b010, 32'h0000_6000, 32'h0, 96'h61);
    check("b2b_ready_t0", 128'(ex_ready), 128'(1'b1));
    step();
    check("b2b_ready_t1", 128'(ex_ready), 128'(1'b0));
    check("b2b_wb_t1", 128'(wb_valid), 128'(1'b0));
    dmem.resp  = 1'b1;
    dmem.rdata = 32'hAAAA_0001;
    step();
    drive_op(1'b1, 1'b0, 3'b010, 32'h0000_6004, 32'h0, 96'h62);
    dmem.resp = 1'b0;
    check("b2b_wb_t2", 128'(wb_valid), 128'(1'b1));
    check("b2b_rdata_1", 128'(wb_mem_rdata), 128'(32'hAAAA_0001));
    check("b2b_ready_t2", 128'(ex_ready), 128'(1'b1));
    step();
    idle_ex();
    check("b2b_wb_t3", 128'(wb_valid), 128'(1'b0));
    check("b2b_addr_2", 128'(dmem.addr), 128'(32'h0000_6004));
    check("b2b_rmask_2", 128'(dmem.rmask), 128'(4'b1111));
    dmem.resp  = 1'b1;
    dmem.rdata = 32'hBBBB_0002;
    step();
    dmem.resp = 1'b0;
    check("b2b_wb_t4", 128'(wb_valid), 128'(1'b1));
    check("b2b_rdata_2", 128'(wb_mem_rdata), 128'(32'hBBBB_0002));
    check("b2b_payload_2", 128'(wb_payload), 128'(96'h62));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
